// File: rtl/scr1_dmem_arb_pkg.sv
// rtl/scr1_dmem_arb_pkg.sv - shared types for the LSU/DMA DMEM arbiter
package scr1_dmem_arb_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        SCR1_DMEM_ARB_FSM_IDLE     = 2'b00,
        SCR1_DMEM_ARB_FSM_BUSY_LSU = 2'b01,
        SCR1_DMEM_ARB_FSM_BUSY_DMA = 2'b10
    } type_scr1_dmem_arb_fsm_e;

    typedef enum logic [1:0] {
        SCR1_DMEM_ARB_SEL_NONE = 2'b00,
        SCR1_DMEM_ARB_SEL_LSU  = 2'b01,
        SCR1_DMEM_ARB_SEL_DMA  = 2'b10
    } type_scr1_dmem_arb_sel_e;

endpackage

// File: rtl/scr1_dmem_arb_sel.sv
// rtl/scr1_dmem_arb_sel.sv - priority and anti-starvation master pick
module scr1_dmem_arb_sel
    import scr1_dmem_arb_pkg::*;
#(
    parameter int unsigned LSU_MAX_GRANTS = 4
)(
    input  logic                    window_i,
    input  logic                    lock_i,
    input  type_scr1_dmem_arb_sel_e lock_sel_i,
    input  logic                    lsu_req_i,
    input  logic                    dma_req_i,
    input  logic [3:0]              starve_cnt_i,
    output type_scr1_dmem_arb_sel_e sel_o
);

    // A pending unacked request keeps its master; otherwise LSU wins unless DMA has waited too long
    always_comb begin
        sel_o = SCR1_DMEM_ARB_SEL_NONE;
        if (!window_i) begin
            sel_o = SCR1_DMEM_ARB_SEL_NONE;
        end else if (lock_i) begin
            sel_o = lock_sel_i;
        end else if (lsu_req_i && dma_req_i && (starve_cnt_i == 4'(LSU_MAX_GRANTS))) begin
            sel_o = SCR1_DMEM_ARB_SEL_DMA;
        end else if (lsu_req_i) begin
            sel_o = SCR1_DMEM_ARB_SEL_LSU;
        end else if (dma_req_i) begin
            sel_o = SCR1_DMEM_ARB_SEL_DMA;
        end
    end

endmodule

// File: rtl/scr1_dmem_arb.sv
// rtl/scr1_dmem_arb.sv - two-master arbiter for the shared DMEM port
module scr1_dmem_arb
    import scr1_dmem_arb_pkg::*;
#(
    parameter int unsigned SCR1_ARB_AWIDTH = SCR1_DMEM_AWIDTH,
    parameter int unsigned SCR1_ARB_DWIDTH = SCR1_DMEM_DWIDTH,
    parameter int unsigned LSU_MAX_GRANTS  = 4
)(
    input  logic                       clk,
    input  logic                       rst_n,
    // master 0: core LSU
    input  logic                       lsu_req_i,
    input  logic                       lsu_cmd_i,
    input  logic [1:0]                 lsu_width_i,
    input  logic [SCR1_ARB_AWIDTH-1:0] lsu_addr_i,
    input  logic [SCR1_ARB_DWIDTH-1:0] lsu_wdata_i,
    output logic                       lsu_req_ack_o,
    output logic [SCR1_ARB_DWIDTH-1:0] lsu_rdata_o,
    output logic [1:0]                 lsu_resp_o,
    // master 1: DMA / debug system bus
    input  logic                       dma_req_i,
    input  logic                       dma_cmd_i,
    input  logic [1:0]                 dma_width_i,
    input  logic [SCR1_ARB_AWIDTH-1:0] dma_addr_i,
    input  logic [SCR1_ARB_DWIDTH-1:0] dma_wdata_i,
    output logic                       dma_req_ack_o,
    output logic [SCR1_ARB_DWIDTH-1:0] dma_rdata_o,
    output logic [1:0]                 dma_resp_o,
    // shared DMEM port
    output logic                       dmem_req_o,
    output logic                       dmem_cmd_o,
    output logic [1:0]                 dmem_width_o,
    output logic [SCR1_ARB_AWIDTH-1:0] dmem_addr_o,
    output logic [SCR1_ARB_DWIDTH-1:0] dmem_wdata_o,
    input  logic                       dmem_req_ack_i,
    input  logic [SCR1_ARB_DWIDTH-1:0] dmem_rdata_i,
    input  logic [1:0]                 dmem_resp_i,
    output logic                       arb_err_o
);

    type_scr1_dmem_arb_fsm_e fsm_q, fsm_d;
    type_scr1_dmem_arb_sel_e owner_q, owner_d;
    type_scr1_dmem_arb_sel_e lock_sel_q, lock_sel_d;
    type_scr1_dmem_arb_sel_e sel;
    logic                    sel_lock_q, sel_lock_d;
    logic [3:0]              starve_cnt_q, starve_cnt_d;
    logic                    resp_vld;
    logic                    window;
    logic                    granted;

    assign resp_vld = (dmem_resp_i != SCR1_MEM_RESP_NOTRDY);
    // A new request may go out when idle, or in the very cycle the outstanding one completes
    assign window   = (fsm_q == SCR1_DMEM_ARB_FSM_IDLE) | resp_vld;

    scr1_dmem_arb_sel #(
        .LSU_MAX_GRANTS (LSU_MAX_GRANTS)
    ) i_sel (
        .window_i     (window),
        .lock_i       (sel_lock_q),
        .lock_sel_i   (lock_sel_q),
        .lsu_req_i    (lsu_req_i),
        .dma_req_i    (dma_req_i),
        .starve_cnt_i (starve_cnt_q),
        .sel_o        (sel)
    );

    // Steer the selected master's command onto the shared port
    always_comb begin
        dmem_req_o   = 1'b0;
        dmem_cmd_o   = 1'b0;
        dmem_width_o = '0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        case (sel)
            SCR1_DMEM_ARB_SEL_LSU: begin
                dmem_req_o   = lsu_req_i;
                dmem_cmd_o   = lsu_cmd_i;
                dmem_width_o = lsu_width_i;
                dmem_addr_o  = lsu_addr_i;
                dmem_wdata_o = lsu_wdata_i;
            end
            SCR1_DMEM_ARB_SEL_DMA: begin
                dmem_req_o   = dma_req_i;
                dmem_cmd_o   = dma_cmd_i;
                dmem_width_o = dma_width_i;
                dmem_addr_o  = dma_addr_i;
                dmem_wdata_o = dma_wdata_i;
            end
            default: ;
        endcase
    end

    assign granted       = dmem_req_o & dmem_req_ack_i & window;
    assign lsu_req_ack_o = granted & (sel == SCR1_DMEM_ARB_SEL_LSU);
    assign dma_req_ack_o = granted & (sel == SCR1_DMEM_ARB_SEL_DMA);

    // Return the response to whoever owns the outstanding transaction; idle responses are dropped
    always_comb begin
        lsu_resp_o  = SCR1_MEM_RESP_NOTRDY;
        dma_resp_o  = SCR1_MEM_RESP_NOTRDY;
        lsu_rdata_o = '0;
        dma_rdata_o = '0;
        if (fsm_q != SCR1_DMEM_ARB_FSM_IDLE) begin
            if (owner_q == SCR1_DMEM_ARB_SEL_DMA) begin
                dma_resp_o  = dmem_resp_i;
                dma_rdata_o = dmem_rdata_i;
            end else begin
                lsu_resp_o  = dmem_resp_i;
                lsu_rdata_o = dmem_rdata_i;
            end
        end
    end

    assign arb_err_o = rst_n & (fsm_q == SCR1_DMEM_ARB_FSM_IDLE) & resp_vld;

    // Next state for the FSM, owner, selection lock and starvation counter
    always_comb begin
        fsm_d        = fsm_q;
        owner_d      = owner_q;
        sel_lock_d   = sel_lock_q;
        lock_sel_d   = lock_sel_q;
        starve_cnt_d = starve_cnt_q;

        if (granted) begin
            fsm_d   = (sel == SCR1_DMEM_ARB_SEL_DMA) ? SCR1_DMEM_ARB_FSM_BUSY_DMA
                                                     : SCR1_DMEM_ARB_FSM_BUSY_LSU;
            owner_d = sel;
        end else if ((fsm_q != SCR1_DMEM_ARB_FSM_IDLE) && resp_vld) begin
            fsm_d   = SCR1_DMEM_ARB_FSM_IDLE;
        end

        if (window) begin
            sel_lock_d = dmem_req_o & ~dmem_req_ack_i;
            lock_sel_d = sel_lock_d ? sel : SCR1_DMEM_ARB_SEL_NONE;
        end

        if (!dma_req_i || dma_req_ack_o) begin
            starve_cnt_d = '0;
        end else if (lsu_req_ack_o && (starve_cnt_q != 4'(LSU_MAX_GRANTS))) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= SCR1_DMEM_ARB_FSM_IDLE;
            owner_q      <= SCR1_DMEM_ARB_SEL_LSU;
            sel_lock_q   <= 1'b0;
            lock_sel_q   <= SCR1_DMEM_ARB_SEL_NONE;
            starve_cnt_q <= '0;
        end else begin
            fsm_q        <= fsm_d;
            owner_q      <= owner_d;
            sel_lock_q   <= sel_lock_d;
            lock_sel_q   <= lock_sel_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef SCR1_TRGT_SIMULATION
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({lsu_req_ack_o, dma_req_ack_o}));

    a_no_req_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        ((fsm_q != SCR1_DMEM_ARB_FSM_IDLE) && !resp_vld) |-> !dmem_req_o);

    a_locked_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (sel_lock_q && window) |-> ($stable(dmem_addr_o) && $stable(dmem_cmd_o) &&
                                    $stable(dmem_width_o) && $stable(dmem_wdata_o)));
`endif

endmodule

// File: tb/tb_scr1_dmem_arb.sv
// tb/tb_scr1_dmem_arb.sv - self-checking bench for scr1_dmem_arb
module tb_scr1_dmem_arb;

    localparam int MAXG = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req_i, lsu_cmd_i, dma_req_i, dma_cmd_i;
    logic [1:0]  lsu_width_i, dma_width_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, dma_addr_i, dma_wdata_i;
    logic        lsu_req_ack_o, dma_req_ack_o;
    logic [31:0] lsu_rdata_o, dma_rdata_o;
    logic [1:0]  lsu_resp_o, dma_resp_o;
    logic        dmem_req_o, dmem_cmd_o;
    logic [1:0]  dmem_width_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_req_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [1:0]  dmem_resp_i;
    logic        arb_err_o;

    int checks = 0;
    int errors = 0;

    scr1_dmem_arb #(.LSU_MAX_GRANTS(MAXG)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_i(lsu_req_i), .lsu_cmd_i(lsu_cmd_i), .lsu_width_i(lsu_width_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_req_ack_o(lsu_req_ack_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_resp_o(lsu_resp_o),
        .dma_req_i(dma_req_i), .dma_cmd_i(dma_cmd_i), .dma_width_i(dma_width_i),
        .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i), .dma_req_ack_o(dma_req_ack_o),
        .dma_rdata_o(dma_rdata_o), .dma_resp_o(dma_resp_o),
        .dmem_req_o(dmem_req_o), .dmem_cmd_o(dmem_cmd_o), .dmem_width_o(dmem_width_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_req_ack_i(dmem_req_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .dmem_resp_i(dmem_resp_i), .arb_err_o(arb_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the outstanding access (0 none, 1 LSU, 2 DMA),
    // who is waiting for an ack, and how many LSU grants DMA has watched go by.
    int          m_owner, m_wait, m_streak;
    int          e_pick;
    logic        e_req, e_win;
    logic        busy, rv;
    logic        x_cmd;
    logic [1:0]  x_width, x_lresp, x_dresp;
    logic [31:0] x_addr, x_wdata, x_lrd, x_drd;

    always @(negedge clk) begin
        busy  = (m_owner != 0);
        rv    = (dmem_resp_i != 2'd0);
        e_win = !busy || rv;
        if (!e_win)                                         e_pick = 0;
        else if (m_wait != 0)                               e_pick = m_wait;
        else if (lsu_req_i && dma_req_i && m_streak >= MAXG) e_pick = 2;
        else if (lsu_req_i)                                 e_pick = 1;
        else if (dma_req_i)                                 e_pick = 2;
        else                                                e_pick = 0;
        e_req   = (e_pick == 1) ? lsu_req_i : (e_pick == 2) ? dma_req_i : 1'b0;
        x_cmd   = (e_pick == 1) ? lsu_cmd_i   : (e_pick == 2) ? dma_cmd_i   : 1'b0;
        x_width = (e_pick == 1) ? lsu_width_i : (e_pick == 2) ? dma_width_i : 2'd0;
        x_addr  = (e_pick == 1) ? lsu_addr_i  : (e_pick == 2) ? dma_addr_i  : 32'd0;
        x_wdata = (e_pick == 1) ? lsu_wdata_i : (e_pick == 2) ? dma_wdata_i : 32'd0;
        x_lresp = (m_owner == 1) ? dmem_resp_i  : 2'd0;
        x_dresp = (m_owner == 2) ? dmem_resp_i  : 2'd0;
        x_lrd   = (m_owner == 1) ? dmem_rdata_i : 32'd0;
        x_drd   = (m_owner == 2) ? dmem_rdata_i : 32'd0;
        chk("m_req",     32'(dmem_req_o),    32'(e_req));
        chk("m_cmd",     32'(dmem_cmd_o),    32'(x_cmd));
        chk("m_width",   32'(dmem_width_o),  32'(x_width));
        chk("m_addr",    dmem_addr_o,        x_addr);
        chk("m_wdata",   dmem_wdata_o,       x_wdata);
        chk("m_lsu_ack", 32'(lsu_req_ack_o), 32'(e_req && dmem_req_ack_i && e_pick == 1));
        chk("m_dma_ack", 32'(dma_req_ack_o), 32'(e_req && dmem_req_ack_i && e_pick == 2));
        chk("m_lsu_resp", 32'(lsu_resp_o),   32'(x_lresp));
        chk("m_dma_resp", 32'(dma_resp_o),   32'(x_dresp));
        chk("m_lsu_rdata", lsu_rdata_o,      x_lrd);
        chk("m_dma_rdata", dma_rdata_o,      x_drd);
        chk("m_err",     32'(arb_err_o),     32'(rst_n && !busy && rv));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0; m_wait = 0; m_streak = 0;
        end else begin
            if (e_req && dmem_req_ack_i) begin
                m_owner = e_pick;
                m_wait  = 0;
            end else begin
                if (m_owner != 0 && dmem_resp_i != 2'd0) m_owner = 0;
                if (e_win) m_wait = e_req ? e_pick : 0;
            end
            if (!dma_req_i || (e_req && dmem_req_ack_i && e_pick == 2)) m_streak = 0;
            else if (e_req && dmem_req_ack_i && e_pick == 1 && m_streak < MAXG) m_streak++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lsu_req_i = 0; lsu_cmd_i = 0; lsu_width_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0;
        dma_req_i = 0; dma_cmd_i = 0; dma_width_i = 0; dma_addr_i = 0; dma_wdata_i = 0;
        dmem_req_ack_i = 0; dmem_rdata_i = 0; dmem_resp_i = 0;
    endtask

    logic [9:0] glsu, gdma;

    initial begin
        rst_n = 0;
        idle();
        m_owner = 0; m_wait = 0; m_streak = 0;
        #2;
        chk("rst_lsu_resp", 32'(lsu_resp_o), 0);
        chk("rst_dma_resp", 32'(dma_resp_o), 0);
        chk("rst_req", 32'(dmem_req_o), 0);
        chk("rst_err", 32'(arb_err_o), 0);
        tick(); tick();
        rst_n = 1;
        tick();

        // 1: LSU LW, ack same cycle, response next cycle
        lsu_req_i = 1; lsu_width_i = 2; lsu_addr_i = 32'h100; dmem_req_ack_i = 1;
        #1;
        chk("t1_ack", 32'(lsu_req_ack_o), 1);
        chk("t1_addr", dmem_addr_o, 32'h100);
        tick();
        idle(); dmem_resp_i = 1; dmem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("t1_lsu_resp", 32'(lsu_resp_o), 1);
        chk("t1_lsu_rdata", lsu_rdata_o, 32'hDEADBEEF);
        chk("t1_dma_resp", 32'(dma_resp_o), 0);
        tick();
        idle();
        tick();

        // 2: both request every cycle; LSU_MAX_GRANTS=4 gives LLLLD LLLLD
        glsu = '0; gdma = '0;
        for (int k = 0; k < 10; k++) begin
            lsu_req_i = 1; lsu_addr_i = 32'h1000 + k; dma_req_i = 1; dma_addr_i = 32'h2000 + k;
            dmem_req_ack_i = 1; dmem_resp_i = (k == 0) ? 2'd0 : 2'd1; dmem_rdata_i = k;
            #1;
            glsu[9-k] = lsu_req_ack_o;
            gdma[9-k] = dma_req_ack_o;
            tick();
        end
        idle(); dmem_resp_i = 1; dmem_rdata_i = 32'h77;
        #1;
        chk("t2_lsu_order", 32'(glsu), 32'b1111011110);
        chk("t2_dma_order", 32'(gdma), 32'b0000100001);
        chk("t2_last_dma_resp", 32'(dma_resp_o), 1);
        tick();
        idle();
        tick();

        // 3: DMA held off by three unacked cycles while LSU joins; lock keeps DMA
        dma_req_i = 1; dma_addr_i = 32'h200;
        #1;
        chk("t3_c1_addr", dmem_addr_o, 32'h200);
        tick();
        lsu_req_i = 1; lsu_addr_i = 32'h2F0;
        #1;
        chk("t3_c2_addr", dmem_addr_o, 32'h200);
        chk("t3_c2_lsu_ack", 32'(lsu_req_ack_o), 0);
        tick();
        #1;
        chk("t3_c3_addr", dmem_addr_o, 32'h200);
        tick();
        dmem_req_ack_i = 1;
        #1;
        chk("t3_c4_dma_ack", 32'(dma_req_ack_o), 1);
        chk("t3_c4_lsu_ack", 32'(lsu_req_ack_o), 0);
        tick();
        dma_req_i = 0; dmem_resp_i = 1; dmem_rdata_i = 32'hA5;
        #1;
        chk("t3_c5_dma_resp", 32'(dma_resp_o), 1);
        chk("t3_c5_dma_rdata", dma_rdata_o, 32'hA5);
        chk("t3_c5_lsu_resp", 32'(lsu_resp_o), 0);
        chk("t3_c5_lsu_ack", 32'(lsu_req_ack_o), 1);
        chk("t3_c5_addr", dmem_addr_o, 32'h2F0);
        tick();
        lsu_req_i = 0; dmem_req_ack_i = 0; dmem_rdata_i = 32'h5A;
        #1;
        chk("t3_c6_lsu_resp", 32'(lsu_resp_o), 1);
        chk("t3_c6_lsu_rdata", lsu_rdata_o, 32'h5A);
        chk("t3_c6_dma_rdata", dma_rdata_o, 0);
        tick();
        idle();
        tick();

        // 4: LSU back-to-back, response and next ack in the same cycle
        lsu_req_i = 1; lsu_addr_i = 32'h300; dmem_req_ack_i = 1;
        tick();
        lsu_addr_i = 32'h304; dmem_resp_i = 1; dmem_rdata_i = 32'h11;
        #1;
        chk("t4_b2b_ack", 32'(lsu_req_ack_o), 1);
        chk("t4_b2b_req", 32'(dmem_req_o), 1);
        chk("t4_b2b_rdata", lsu_rdata_o, 32'h11);
        tick();
        lsu_req_i = 0; dmem_req_ack_i = 0; dmem_rdata_i = 32'h22;
        #1;
        chk("t4_second_resp", 32'(lsu_resp_o), 1);
        chk("t4_second_rdata", lsu_rdata_o, 32'h22);
        tick();
        idle();
        tick();

        // 5: DMA SW answered with RDY_ER, then a spurious response while idle
        dma_req_i = 1; dma_cmd_i = 1; dma_width_i = 2; dma_addr_i = 32'h400;
        dma_wdata_i = 32'hCAFE; dmem_req_ack_i = 1;
        #1;
        chk("t5_cmd", 32'(dmem_cmd_o), 1);
        chk("t5_wdata", dmem_wdata_o, 32'hCAFE);
        tick();
        idle(); dmem_resp_i = 2;
        #1;
        chk("t5_dma_err_resp", 32'(dma_resp_o), 2);
        chk("t5_lsu_resp", 32'(lsu_resp_o), 0);
        chk("t5_no_arb_err", 32'(arb_err_o), 0);
        tick();
        dmem_resp_i = 0;
        tick();
        dmem_resp_i = 1;
        #1;
        chk("t5_spur_err", 32'(arb_err_o), 1);
        chk("t5_spur_lsu", 32'(lsu_resp_o), 0);
        chk("t5_spur_dma", 32'(dma_resp_o), 0);
        tick();
        dmem_resp_i = 0;
        #1;
        chk("t5_err_pulse_end", 32'(arb_err_o), 0);
        tick();

        // 6: reset while DMA owns the port
        dma_req_i = 1; dma_addr_i = 32'h600; dmem_req_ack_i = 1;
        tick();
        idle(); dmem_resp_i = 1; dmem_rdata_i = 32'h55;
        #1;
        chk("t6_pre_rst_resp", 32'(dma_resp_o), 1);
        #1;
        rst_n = 0;
        #1;
        chk("t6_rst_dma_resp", 32'(dma_resp_o), 0);
        chk("t6_rst_dma_rdata", dma_rdata_o, 0);
        chk("t6_rst_err", 32'(arb_err_o), 0);
        tick();
        dmem_resp_i = 0;
        tick();
        rst_n = 1;
        tick();
        lsu_req_i = 1; lsu_addr_i = 32'h500; dmem_req_ack_i = 1;
        #1;
        chk("t6_post_ack", 32'(lsu_req_ack_o), 1);
        chk("t6_post_addr", dmem_addr_o, 32'h500);
        tick();
        idle(); dmem_resp_i = 1; dmem_rdata_i = 32'h77;
        #1;
        chk("t6_post_resp", 32'(lsu_resp_o), 1);
        chk("t6_post_rdata", lsu_rdata_o, 32'h77);
        tick();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
